pipe_hazard_ctl: RTL
====================

# pipe_hazard_ctl

Parametrised hazard, forwarding and stall controller for the five-stage pipelined CPU. It sits beside the ID-stage decoder and supplies the pipeline register enables, bubble/flush strobes and operand-forwarding selects. Beyond load-use stalls and EXE/MEM forwarding, it adds:
- Operand-use qualification, so no false stalls.
- Optional write-back forwarding.
- A branch-flush mode.
- A multi-cycle data-memory wait state machine with timeout.
- Saturating stall/flush performance counters.

## Interface
Parameters:
- REG_AW, 5: register-number width.
- DELAY_SLOT, 1: 1 = branch delay slot, never flush IF/ID; 0 = flush IF/ID on a taken branch/jump.
- MEM_TIMEOUT, 255: wait cycles before `mem_err` sets (≥1).
- PERF_W, 16: performance counter width.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  synchronous, active-low reset.
- id_rs, id_rt  in  REG_AW  source register numbers in ID.
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs/rt.
- id_branch  in  1  taken branch/jump resolved in ID.
- e_wreg, e_m2reg  in  1  EXE-stage write-enable and load flag.
- e_rn  in  REG_AW  EXE-stage destination register.
- m_wreg, m_m2reg  in  1  MEM-stage write-enable and load flag.
- m_rn  in  REG_AW  MEM-stage destination register.
- w_wreg  in  1  WB-stage write-enable.
- w_rn  in  REG_AW  WB-stage destination register.
- m_mem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes this cycle.
- wpcir  out  1  PC and IF/ID write enable.
- id_bubble  out  1  zero ID→EXE control signals.
- ir_flush  out  1  load a NOP into IF/ID.
- freeze  out  1  hold ID/EXE, EXE/MEM and MEM/WB registers.
- fwda, fwdb  out  3  operand source select: 000 regfile, 001 EXE ALU, 010 MEM ALU, 011 MEM load data, 100 WB result.
- mem_err  out  1  sticky memory timeout flag.
- stall_cnt, flush_cnt  out  PERF_W  saturating event counters.

## Operation
- FSM states: RUN and MWAIT.
  - RUN→MWAIT when `m_mem_req & ~mem_ready`.
  - MWAIT→RUN when `mem_ready`.
  - Timer clears on entry to MWAIT and increments each MWAIT cycle. When it reaches MEM_TIMEOUT, `mem_err` sets (sticky until reset) and the FSM stays in MWAIT.
- `freeze = (state==MWAIT & ~mem_ready) | (state==RUN & m_mem_req & ~mem_ready)`. Whenever `freeze` is high: `wpcir=0`, `id_bubble=0`, `ir_flush=0`.
- Load-use: `lu = e_wreg & e_m2reg & e_rn!=0 & ((id_use_rs & e_rn==id_rs) | (id_use_rt & e_rn==id_rt))`. When `lu & ~freeze`: `wpcir=0`, `id_bubble=1`, and `id_branch` is ignored that cycle.
- Flush: `ir_flush = ~DELAY_SLOT & id_branch & ~lu & ~freeze`.
- `wpcir = ~freeze & ~lu`.
- Forward priority per operand, first match wins, all require a destination register ≠ 0:
  1. E (`e_wreg & ~e_m2reg`) → 001
  2. M (`m_wreg & ~m_m2reg`) → 010
  3. M load (`m_wreg & m_m2reg`) → 011
  4. W (`w_wreg`) → 100
  5. otherwise 000
- A select is driven 000 when the corresponding `id_use_*` is 0.
- `stall_cnt` increments on each cycle with `~wpcir`. `flush_cnt` increments on each `ir_flush` cycle. Both saturate at all-ones.

## Timing
- `wpcir`, `id_bubble`, `ir_flush`, `freeze` and `fwda`/`fwdb` are combinational, with zero latency from their inputs.
- State, timer, `mem_err` and the counters update on the `clock` edge.
- While `resetn=0`: state=RUN, timer=0, `mem_err=0`, counters=0, `wpcir=1`, `id_bubble=0`, `ir_flush=0`, `freeze=0`, `fwda=fwdb=000`.
- Reset asserted mid-MWAIT returns to RUN on the next edge.
- Load-use stall lasts exactly one cycle; the next cycle forwards 011.
- `mem_ready` high in the same cycle as the request means no freeze and no MWAIT.

## Configuration
- HAZ_WB_FWD_EN defined: W-stage forwarding (code 100) is generated.
- HAZ_WB_FWD_EN not defined: code 100 is never produced; the register file must write in the first half-cycle. Port widths are unchanged.

## Structure
- Package `pipe_pkg`: forward-select constants (FWD_REG, FWD_EALU, FWD_MALU, FWD_MMEM, FWD_WB), FSM state enum, and the REG_AW default.
- Sub-module `fwd_sel`: one per operand, instantiated twice (rs, rt).
- FSM, timer and counters stay in the top module.

## Test plan
- Load in EXE writing r5, ID reads `id_rs=5`, `id_use_rs=1` → 1 cycle `wpcir=0`, `id_bubble=1`; next cycle `fwda=011`; `stall_cnt=1`.
- Same, but `id_use_rs=0` → no stall, `fwda=000`.
- E and M both write r3, ID reads `rt=3` → `fwdb=001`; with `e_rn=0` instead → `fwdb=010`; with W only and HAZ_WB_FWD_EN → 100, without → 000.
- `DELAY_SLOT=0`, `id_branch=1`, no hazards → `ir_flush=1`, `flush_cnt=1`; with `lu` high simultaneously → `ir_flush=0`.
- `m_mem_req=1`, `mem_ready` low for 3 cycles → `freeze=1` for 3 cycles, MWAIT entered and exited, `stall_cnt=3`.
- `MEM_TIMEOUT=4`, `mem_ready` held low → `mem_err=1` after 4 MWAIT cycles and stays set; `resetn=0` for one edge clears all state.

Source files
------------

// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// HAZ_WB_FWD_EN enables write-back stage forwarding (select code 100).
package pipe_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  localparam logic [2:0] FWD_REG  = 3'b000;
  localparam logic [2:0] FWD_EALU = 3'b001;
  localparam logic [2:0] FWD_MALU = 3'b010;
  localparam logic [2:0] FWD_MMEM = 3'b011;
  localparam logic [2:0] FWD_WB   = 3'b100;

`ifdef HAZ_WB_FWD_EN
  localparam bit WB_FWD_ON = 1'b1;
`else
  localparam bit WB_FWD_ON = 1'b0;
`endif

  typedef enum logic {StRun, StMwait} hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Pipeline-to-hazard-controller signal bundle; the controller takes the slave view.
interface pipe_hazard_ctl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PERF_W = 16
);
  logic [REG_AW-1:0] id_rs, id_rt, e_rn, m_rn, w_rn;
  logic              id_use_rs, id_use_rt, id_branch;
  logic              e_wreg, e_m2reg, m_wreg, m_m2reg, w_wreg;
  logic              m_mem_req, mem_ready;
  logic              wpcir, id_bubble, ir_flush, freeze, mem_err;
  logic [2:0]        fwda, fwdb;
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
    output e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn, w_wreg, w_rn,
    output m_mem_req, mem_ready,
    input  wpcir, id_bubble, ir_flush, freeze, fwda, fwdb, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
    input  e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn, w_wreg, w_rn,
    input  m_mem_req, mem_ready,
    output wpcir, id_bubble, ir_flush, freeze, fwda, fwdb, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctl_fwd_sel.sv
// Per-operand forwarding source select (EXE ALU > MEM ALU > MEM load > WB > regfile).
// WB forwarding is only produced when HAZ_WB_FWD_EN is defined.
module fwd_sel import pipe_pkg::*; #(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              i_en,
  input  logic [REG_AW-1:0] i_rn,
  input  logic              i_e_wreg,
  input  logic              i_e_m2reg,
  input  logic [REG_AW-1:0] i_e_rn,
  input  logic              i_m_wreg,
  input  logic              i_m_m2reg,
  input  logic [REG_AW-1:0] i_m_rn,
  input  logic              i_w_wreg,
  input  logic [REG_AW-1:0] i_w_rn,
  output logic [2:0]        o_fwd
);

  logic w_e_hit, w_m_hit, w_w_hit;

  always_comb begin
    w_e_hit = i_e_wreg & (i_e_rn != '0) & (i_e_rn == i_rn);
    w_m_hit = i_m_wreg & (i_m_rn != '0) & (i_m_rn == i_rn);
    w_w_hit = WB_FWD_ON & i_w_wreg & (i_w_rn != '0) & (i_w_rn == i_rn);
    o_fwd   = FWD_REG;
    if (!i_en) o_fwd = FWD_REG;
    else if (w_e_hit & ~i_e_m2reg) o_fwd = FWD_EALU;
    else if (w_m_hit & ~i_m_m2reg) o_fwd = FWD_MALU;
    else if (w_m_hit) o_fwd = FWD_MMEM;
    else if (w_w_hit) o_fwd = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Hazard, forwarding and stall controller: load-use stall, branch flush, data-memory
// wait FSM with sticky timeout, saturating perf counters. HAZ_WB_FWD_EN adds WB forwarding.
module pipe_hazard_ctl import pipe_pkg::*; #(
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned DELAY_SLOT  = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned PERF_W      = 16
) (
  input logic              clock,
  input logic              resetn,
  pipe_hazard_ctl_if.slave hz
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_L = TW'(MEM_TIMEOUT);

  hz_state_e         r_state;
  logic [TW-1:0]     r_timer;
  logic              r_mem_err;
  logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_mem_stall, w_freeze, w_lu, w_wpcir, w_flush;
  logic [2:0] w_fwda, w_fwdb;

  // All combinational strobes are forced to their idle values while in reset.
  always_comb begin
    w_mem_stall = (r_state == StMwait) ? ~hz.mem_ready : (hz.m_mem_req & ~hz.mem_ready);
    w_freeze    = resetn & w_mem_stall;
    w_lu        = resetn & hz.e_wreg & hz.e_m2reg & (hz.e_rn != '0) &
                  ((hz.id_use_rs & (hz.e_rn == hz.id_rs)) |
                   (hz.id_use_rt & (hz.e_rn == hz.id_rt)));
    w_wpcir     = ~w_freeze & ~w_lu;
    w_flush     = resetn & (DELAY_SLOT == 0) & hz.id_branch & ~w_lu & ~w_freeze;
  end

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs (
    .i_en     (resetn & hz.id_use_rs),
    .i_rn     (hz.id_rs),
    .i_e_wreg (hz.e_wreg),
    .i_e_m2reg(hz.e_m2reg),
    .i_e_rn   (hz.e_rn),
    .i_m_wreg (hz.m_wreg),
    .i_m_m2reg(hz.m_m2reg),
    .i_m_rn   (hz.m_rn),
    .i_w_wreg (hz.w_wreg),
    .i_w_rn   (hz.w_rn),
    .o_fwd    (w_fwda)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_rt (
    .i_en     (resetn & hz.id_use_rt),
    .i_rn     (hz.id_rt),
    .i_e_wreg (hz.e_wreg),
    .i_e_m2reg(hz.e_m2reg),
    .i_e_rn   (hz.e_rn),
    .i_m_wreg (hz.m_wreg),
    .i_m_m2reg(hz.m_m2reg),
    .i_m_rn   (hz.m_rn),
    .i_w_wreg (hz.w_wreg),
    .i_w_rn   (hz.w_rn),
    .o_fwd    (w_fwdb)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= StRun;
      r_timer     <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (hz.m_mem_req & ~hz.mem_ready) begin
            r_state <= StMwait;
            r_timer <= '0;
          end
        end
        StMwait: begin
          if (hz.mem_ready) begin
            r_state <= StRun;
          end else begin
            // Timer saturates at the limit; the error flag is set as the limit is reached.
            if (r_timer != TO_L) r_timer <= r_timer + 1'b1;
            if (r_timer >= TO_L - 1'b1) r_mem_err <= 1'b1;
          end
        end
      endcase
      if (~w_wpcir && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign hz.wpcir     = w_wpcir;
  assign hz.id_bubble = w_lu & ~w_freeze;
  assign hz.ir_flush  = w_flush;
  assign hz.freeze    = w_freeze;
  assign hz.fwda      = w_fwda;
  assign hz.fwdb      = w_fwdb;
  assign hz.mem_err   = r_mem_err;
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule
